tlb_op_ctrl: RTL and testbench

- Initiator side of the TLB maintenance port. Sequences TLBP, TLBR, TLBWI and TLBWR instructions from the CP0/execute stage into the split-mode TLB.
- Drives tlb_index, tlb_we, tlb_wdata and tlbp_entryhi. Captures tlb_rdata and tlbp_index, and returns CP0 Index/Entry writeback.
- Owns the CP0 Random register and the TLBWR index selection. Sits between the CP0 unit and the TLB.

---
 rtl/tlb_op_ctrl.sv | 132 +++++++++++++
 tb/tb_tlb_op_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance initiator: sequences TLBP/TLBR/TLBWI/TLBWR into the TLB,
// returns CP0 Index/Entry writeback and owns the CP0 Random register.
module tlb_op_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int RANDOM_MAX = (1 << INDEX_BITS) - 1,
    parameter int EHI_BITS   = 27,
    parameter int ENTRY_BITS = 90
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    output logic                  op_ready,
    input  logic                  flush,
    input  logic [EHI_BITS-1:0]   cp0_entryhi,
    input  logic [ENTRY_BITS-1:0] cp0_entry,
    input  logic [INDEX_BITS-1:0] cp0_index,
    input  logic [INDEX_BITS-1:0] cp0_wired,
    input  logic                  wired_we,
    output logic [INDEX_BITS-1:0] random,
    output logic [INDEX_BITS-1:0] tlb_index,
    output logic                  tlb_we,
    output logic [ENTRY_BITS-1:0] tlb_wdata,
    input  logic [ENTRY_BITS-1:0] tlb_rdata,
    output logic [EHI_BITS-1:0]   tlbp_entryhi,
    input  logic                  tlbp_p,
    input  logic [INDEX_BITS-1:0] tlbp_idx,
    output logic                  done,
    output logic                  cp0_index_we,
    output logic [31:0]           cp0_index_wdata,
    output logic                  cp0_entry_we,
    output logic [ENTRY_BITS-1:0] cp0_entry_wdata,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;
    localparam logic [INDEX_BITS-1:0] RAND_TOP = INDEX_BITS'(RANDOM_MAX);
    localparam logic [INDEX_BITS-1:0] ONE      = INDEX_BITS'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q;
    logic                    accept;
    logic                    op_ready_d, tlb_we_d, done_d, cp0_index_we_d, cp0_entry_we_d;
    logic [INDEX_BITS-1:0]   tlb_index_d;
    logic [ENTRY_BITS-1:0]   tlb_wdata_d, cp0_entry_wdata_d;
    logic [EHI_BITS-1:0]     tlbp_entryhi_d;
    logic [31:0]             cp0_index_wdata_d;

    assign accept    = (state_q == IDLE) && op_valid && !flush;
    assign fsm_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the tlb_* registers double as
    // the latched operands for the op in flight.
    always_comb begin
        op_ready_d        = (state_d == IDLE);
        tlb_we_d          = accept && op[1];
        done_d            = (state_q == EXEC);
        cp0_index_we_d    = (state_q == EXEC) && (op_q == OP_TLBP);
        cp0_entry_we_d    = (state_q == EXEC) && (op_q == OP_TLBR);
        tlb_index_d       = tlb_index;
        tlb_wdata_d       = tlb_wdata;
        tlbp_entryhi_d    = tlbp_entryhi;
        cp0_index_wdata_d = cp0_index_wdata;
        cp0_entry_wdata_d = cp0_entry_wdata;
        if (accept) begin
            tlb_index_d    = (op == OP_TLBWR) ? random : cp0_index;
            tlb_wdata_d    = cp0_entry;
            tlbp_entryhi_d = cp0_entryhi;
        end
        if (cp0_index_we_d) begin
            cp0_index_wdata_d     = '0;
            cp0_index_wdata_d[31] = tlbp_p;
            if (!tlbp_p) cp0_index_wdata_d[INDEX_BITS-1:0] = tlbp_idx;
        end
        if (cp0_entry_we_d) cp0_entry_wdata_d = tlb_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q            <= '0;
            op_ready        <= 1'b1;
            tlb_we          <= 1'b0;
            done            <= 1'b0;
            cp0_index_we    <= 1'b0;
            cp0_entry_we    <= 1'b0;
            tlb_index       <= '0;
            tlb_wdata       <= '0;
            tlbp_entryhi    <= '0;
            cp0_index_wdata <= '0;
            cp0_entry_wdata <= '0;
        end else begin
            if (accept) op_q <= op;
            op_ready        <= op_ready_d;
            tlb_we          <= tlb_we_d;
            done            <= done_d;
            cp0_index_we    <= cp0_index_we_d;
            cp0_entry_we    <= cp0_entry_we_d;
            tlb_index       <= tlb_index_d;
            tlb_wdata       <= tlb_wdata_d;
            tlbp_entryhi    <= tlbp_entryhi_d;
            cp0_index_wdata <= cp0_index_wdata_d;
            cp0_entry_wdata <= cp0_entry_wdata_d;
        end
    end

    // Random free-runs down to Wired then wraps; a Wired write restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                random <= RAND_TOP;
        else if (wired_we || random <= cp0_wired) random <= RAND_TOP;
        else                                    random <= random - ONE;
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural TLB (write, read, probe).
module tb_tlb_op_ctrl;

    localparam int IB = 5;
    localparam int EB = 27;
    localparam int NB = 90;
    localparam logic [1:0] TLBP = 2'd0, TLBR = 2'd1, TLBWI = 2'd2, TLBWR = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid, flush, wired_we;
    logic [1:0]    op;
    logic [EB-1:0] cp0_entryhi;
    logic [NB-1:0] cp0_entry;
    logic [IB-1:0] cp0_index, cp0_wired;
    logic          op_ready, tlb_we, done, cp0_index_we, cp0_entry_we;
    logic [IB-1:0] random, tlb_index, tlbp_idx;
    logic [NB-1:0] tlb_wdata, tlb_rdata, cp0_entry_wdata;
    logic [EB-1:0] tlbp_entryhi;
    logic          tlbp_p;
    logic [31:0]   cp0_index_wdata;
    logic [1:0]    fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tlb_op_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .flush(flush), .cp0_entryhi(cp0_entryhi), .cp0_entry(cp0_entry),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
        .random(random), .tlb_index(tlb_index), .tlb_we(tlb_we), .tlb_wdata(tlb_wdata),
        .tlb_rdata(tlb_rdata), .tlbp_entryhi(tlbp_entryhi), .tlbp_p(tlbp_p),
        .tlbp_idx(tlbp_idx), .done(done), .cp0_index_we(cp0_index_we),
        .cp0_index_wdata(cp0_index_wdata), .cp0_entry_we(cp0_entry_we),
        .cp0_entry_wdata(cp0_entry_wdata), .fsm_state(fsm_state)
    );

    // Behavioural TLB: registered write, combinational read and probe.
    logic [NB-1:0] mem [32] = '{default: '0};
    always @(posedge clk) if (tlb_we) mem[tlb_index] <= tlb_wdata;
    assign tlb_rdata = mem[tlb_index];
    always_comb begin
        tlbp_p   = 1'b1;
        tlbp_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mem[i][NB-1 -: EB] == tlbp_entryhi) begin
                tlbp_p   = 1'b0;
                tlbp_idx = IB'(i);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] mk(input logic [EB-1:0] hi, input logic [62:0] lo);
        return {hi, lo};
    endfunction

    typedef struct {
        logic [1:0]    op;
        logic [IB-1:0] idx;
        logic [EB-1:0] ehi;
        logic [NB-1:0] ent;
        logic          exp_we;
        logic [IB-1:0] exp_tidx;
        logic          exp_iwe;
        logic [31:0]   exp_iwd;
        logic          exp_ewe;
        logic [NB-1:0] exp_ewd;
    } vec_t;

    vec_t vecs[10];

    // Called at a negedge with the FSM idle; walks accept, EXEC, DONE, IDLE.
    task automatic do_op(input vec_t v);
        chk("pre_ready", op_ready, 1);
        op_valid = 1; op = v.op; cp0_index = v.idx; cp0_entryhi = v.ehi; cp0_entry = v.ent;
        @(negedge clk);
        op_valid = 0;
        chk("exec_ready", op_ready, 0);
        chk("exec_we", tlb_we, v.exp_we);
        chk("exec_index", tlb_index, v.exp_tidx);
        chk("exec_done", done, 0);
        if (v.exp_we) chk("exec_wdata", tlb_wdata, v.ent);
        if (v.op == TLBP) chk("exec_probe_key", tlbp_entryhi, v.ehi);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_we", tlb_we, 0);
        chk("done_index_we", cp0_index_we, v.exp_iwe);
        chk("done_entry_we", cp0_entry_we, v.exp_ewe);
        if (v.exp_iwe) chk("done_index_wdata", cp0_index_wdata, v.exp_iwd);
        if (v.exp_ewe) chk("done_entry_wdata", cp0_entry_wdata, v.exp_ewd);
        @(negedge clk);
        chk("post_ready", op_ready, 1);
        chk("post_done", done, 0);
    endtask

    function automatic vec_t mkv(input logic [1:0] o, input logic [IB-1:0] idx,
                                 input logic [EB-1:0] ehi, input logic [NB-1:0] ent,
                                 input logic [31:0] iwd, input logic [NB-1:0] ewd);
        vec_t v;
        v.op = o; v.idx = idx; v.ehi = ehi; v.ent = ent;
        v.exp_we = o[1]; v.exp_tidx = idx;
        v.exp_iwe = (o == TLBP); v.exp_iwd = iwd;
        v.exp_ewe = (o == TLBR); v.exp_ewd = ewd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NB-1:0] e1, e2, e3, e4, e5;
        vec_t v;
        int   waited;
        e1 = mk(27'h0123456, 63'h1111);
        e2 = mk(27'h0222222, 63'h2222);
        e3 = mk(27'h0333333, 63'h3333);
        e4 = mk(27'h0444444, 63'h4444);
        e5 = mk(27'h0555555, 63'h5555);
        vecs[0] = mkv(TLBWI, 5'h13, '0,          e1, '0,            '0);
        vecs[1] = mkv(TLBR,  5'h13, '0,          '0, '0,            e1);
        vecs[2] = mkv(TLBP,  5'h0a, 27'h0123456, '0, 32'h0000_0013, '0);
        vecs[3] = mkv(TLBP,  5'h0a, 27'h0654321, '0, 32'h8000_0000, '0);
        vecs[4] = mkv(TLBWI, 5'h02, '0,          e2, '0,            '0);
        vecs[5] = mkv(TLBP,  5'h0a, 27'h0222222, '0, 32'h0000_0002, '0);
        vecs[6] = mkv(TLBR,  5'h02, '0,          '0, '0,            e2);
        vecs[7] = mkv(TLBWI, 5'h13, '0,          e3, '0,            '0);
        vecs[8] = mkv(TLBR,  5'h13, '0,          '0, '0,            e3);
        vecs[9] = mkv(TLBP,  5'h0a, 27'h0123456, '0, 32'h8000_0000, '0);

        rst = 1; op_valid = 0; op = 0; flush = 0; wired_we = 0;
        cp0_entryhi = '0; cp0_entry = '0; cp0_index = '0; cp0_wired = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_random", random, 31);
        chk("rst_we", tlb_we, 0);
        chk("rst_done", done, 0);
        chk("rst_index", tlb_index, 0);
        chk("rst_iwe", cp0_index_we, 0);
        chk("rst_ewe", cp0_entry_we, 0);
        chk("rst_iwd", cp0_index_wdata, 0);
        chk("rst_ewd", cp0_entry_wdata, 0);
        chk("rst_wdata", tlb_wdata, 0);
        chk("rst_key", tlbp_entryhi, 0);
        chk("rst_state", fsm_state, 0);
        rst = 0;

        // Random with Wired=0: 31 down to 0, then wrap to 31.
        for (int k = 0; k < 40; k++) begin
            chk("rand_count", random, 128'(31 - (k % 32)));
            chk("rand_ready", op_ready, 1);
            chk("rand_we", tlb_we, 0);
            @(negedge clk);
        end

        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // TLBWR picks up Random as registered in the accept cycle.
        cp0_wired = 5'd8;
        waited = 0;
        while (random != 5'd9 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_random_9", random, 9);
        op_valid = 1; op = TLBWR; cp0_index = 5'h01; cp0_entry = e4; cp0_entryhi = '0;
        @(negedge clk);
        op_valid = 0;
        chk("wr_index", tlb_index, 9);
        chk("wr_we", tlb_we, 1);
        chk("wr_wdata", tlb_wdata, e4);
        chk("wr_rand_8", random, 8);
        @(negedge clk);
        chk("wr_rand_wrap", random, 31);
        chk("wr_done", done, 1);
        chk("wr_no_iwe", cp0_index_we, 0);
        chk("wr_no_ewe", cp0_entry_we, 0);
        @(negedge clk);
        chk("rand_30", random, 30);
        wired_we = 1;
        @(negedge clk);
        wired_we = 0;
        chk("wired_we_force", random, 31);
        @(negedge clk);
        chk("after_wired_we", random, 30);
        cp0_wired = '0;
        do_op(mkv(TLBR, 5'h09, '0, '0, '0, e4));

        // Flush blocks acceptance in IDLE.
        op_valid = 1; flush = 1; op = TLBWI; cp0_index = 5'h05; cp0_entry = e5;
        @(negedge clk);
        op_valid = 0; flush = 0;
        chk("flush_ready", op_ready, 1);
        chk("flush_we", tlb_we, 0);
        @(negedge clk);
        chk("flush_done", done, 0);
        chk("flush_we2", tlb_we, 0);
        chk("flush_no_write", mem[5], 0);

        // Flush during EXEC does not cancel the write.
        op_valid = 1; op = TLBWI; cp0_index = 5'h05; cp0_entry = e5;
        @(negedge clk);
        op_valid = 0; flush = 1;
        chk("xflush_we", tlb_we, 1);
        @(negedge clk);
        flush = 0;
        chk("xflush_done", done, 1);
        @(negedge clk);
        do_op(mkv(TLBR, 5'h05, '0, '0, '0, e5));

        // Asynchronous reset in EXEC drops tlb_we before the next edge.
        op_valid = 1; op = TLBWI; cp0_index = 5'h07; cp0_entry = e1;
        @(negedge clk);
        op_valid = 0;
        chk("arst_we_before", tlb_we, 1);
        #2 rst = 1;
        #1;
        chk("arst_we", tlb_we, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", op_ready, 1);
        chk("arst_state", fsm_state, 0);
        @(negedge clk);
        rst = 0;
        chk("arst_rel_ready", op_ready, 1);
        chk("arst_rel_random", random, 31);
        do_op(mkv(TLBR, 5'h07, '0, '0, '0, '0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
